// File: rtl/copro_bcd2bin.sv
// copro_bcd2bin: multi-cycle packed-BCD to binary converter with tagged write-back
module copro_bcd2bin #(
    parameter int unsigned XLEN     = 32,
    parameter type         hartid_t = logic,
    parameter type         id_t     = logic
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] operand_i,
    input  hartid_t         hartid_i,
    input  id_t             id_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            result_ready_i,
    output logic [XLEN-1:0] result_o,
    output hartid_t         hartid_o,
    output id_t             id_o,
    output logic [4:0]      rd_o,
    output logic            we_o,
    output logic            error_o
);
    localparam int unsigned ND = XLEN / 4;
    localparam int unsigned CW = $clog2(ND + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    hartid_t         hartid_q, hartid_d;
    id_t             id_q, id_d;
    logic [4:0]      rd_q, rd_d;
    logic [3:0]      dig;

    assign dig     = op_q[XLEN-1 -: 4];
    assign ready_o = state_q == IDLE;
    assign valid_o = state_q == DONE;

    // Outputs are masked to zero outside DONE; an erroneous operand suppresses the write.
    always_comb begin
        result_o = (valid_o && !err_q) ? acc_q : '0;
        we_o     = valid_o && !err_q;
        error_o  = valid_o && err_q;
        hartid_o = valid_o ? hartid_q : '0;
        id_o     = valid_o ? id_q : '0;
        rd_o     = valid_o ? rd_q : '0;
    end

    // Next-state logic: accept, accumulate one digit MSB-first per cycle, hold result; flush wins.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        hartid_d = hartid_q;
        id_d     = id_q;
        rd_d     = rd_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (valid_i) begin
                    state_d  = CONV;
                    op_d     = operand_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    hartid_d = hartid_i;
                    id_d     = id_i;
                    rd_d     = rd_i;
                end
                CONV: begin
                    acc_d   = (acc_q << 3) + (acc_q << 1) + XLEN'(dig);
                    op_d    = op_q << 4;
                    err_d   = err_q | (dig > 4'd9);
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_q == CW'(ND - 1)) ? DONE : CONV;
                end
                DONE: state_d = result_ready_i ? IDLE : DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            hartid_q <= '0;
            id_q     <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            hartid_q <= hartid_d;
            id_q     <= id_d;
            rd_q     <= rd_d;
        end
    end
endmodule

// File: tb/tb_copro_bcd2bin.sv
// tb_copro_bcd2bin: directed self-checking bench for the BCD to binary converter
module tb_copro_bcd2bin;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] operand_i;
    logic [1:0]  hartid_i;
    logic [3:0]  id_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        valid_o;
    logic        result_ready_i;
    logic [31:0] result_o;
    logic [1:0]  hartid_o;
    logic [3:0]  id_o;
    logic [4:0]  rd_o;
    logic        we_o;
    logic        error_o;

    int errors = 0;
    int checks = 0;

    copro_bcd2bin #(.XLEN(32), .hartid_t(logic [1:0]), .id_t(logic [3:0])) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .operand_i(operand_i), .hartid_i(hartid_i), .id_i(id_i), .rd_i(rd_i),
        .flush_i(flush_i), .valid_o(valid_o), .result_ready_i(result_ready_i),
        .result_o(result_o), .hartid_o(hartid_o), .id_o(id_o), .rd_o(rd_o),
        .we_o(we_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (valid_o !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
    endtask

    task automatic convert(input string nm, input logic [31:0] op, input logic [1:0] h,
                           input logic [3:0] i, input logic [4:0] r,
                           input logic [31:0] exp_res, input logic exp_err);
        int cyc;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before: got %b want 1", nm, ready_o);
        end
        valid_i = 1'b1; operand_i = op; hartid_i = h; id_i = i; rd_i = r;
        step();
        valid_i = 1'b0;
        wait_valid(cyc);
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL %s latency: got %0d want 8", nm, cyc);
        end
        checks++;
        if (result_o !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %h want %h", nm, result_o, exp_res);
        end
        checks++;
        if (we_o !== !exp_err || error_o !== exp_err) begin
            errors++;
            $display("FAIL %s we/err: got %b/%b want %b/%b", nm, we_o, error_o, !exp_err, exp_err);
        end
        checks++;
        if (hartid_o !== h || id_o !== i || rd_o !== r) begin
            errors++;
            $display("FAIL %s tags: got %h/%h/%h want %h/%h/%h", nm, hartid_o, id_o, rd_o, h, i, r);
        end
        result_ready_i = 1'b1;
        step();
        result_ready_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 32'h0 || rd_o !== 5'h0) begin
            errors++;
            $display("FAIL %s release: got valid=%b ready=%b res=%h rd=%h want 0 1 0 0",
                     nm, valid_o, ready_o, result_o, rd_o);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || we_o !== 1'b0 || error_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got r=%b v=%b we=%b e=%b want 1 0 0 0", ready_o, valid_o, we_o, error_o);
        end
        checks++;
        if (result_o !== 32'h0 || hartid_o !== 2'h0 || id_o !== 4'h0 || rd_o !== 5'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h want zeros", result_o, hartid_o, id_o, rd_o);
        end
    endtask

    task automatic test_convert();
        convert("bcd42", 32'h00000042, 2'd1, 4'd3, 5'd5, 32'h0000002A, 1'b0);
        convert("bcd_max", 32'h99999999, 2'd2, 4'd7, 5'd31, 32'h05F5E0FF, 1'b0);
        convert("bcd_zero", 32'h00000000, 2'd0, 4'd1, 5'd1, 32'h00000000, 1'b0);
    endtask

    task automatic test_error();
        convert("err_low", 32'h0000001A, 2'd3, 4'd9, 5'd10, 32'h0, 1'b1);
        convert("err_top", 32'hF0000000, 2'd1, 4'd2, 5'd3, 32'h0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int cyc;
        valid_i = 1'b1; operand_i = 32'h00000042; hartid_i = 2'd1; id_i = 4'd3; rd_i = 5'd5;
        step();
        valid_i = 1'b0;
        wait_valid(cyc);
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL bp_latency: got %0d want 8", cyc);
        end
        valid_i = 1'b1; operand_i = 32'h00000099; hartid_i = 2'd2; id_i = 4'd4; rd_i = 5'd6;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || result_o !== 32'h2A || rd_o !== 5'd5 || id_o !== 4'd3) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b r=%b res=%h rd=%h id=%h want 1 0 2a 05 3",
                         k, valid_o, ready_o, result_o, rd_o, id_o);
            end
        end
        result_ready_i = 1'b1;
        step();
        result_ready_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got r=%b v=%b want 1 0", ready_o, valid_o);
        end
        step();
        valid_i = 1'b0;
        wait_valid(cyc);
        checks++;
        if (cyc !== 8 || result_o !== 32'h63 || rd_o !== 5'd6 || hartid_o !== 2'd2) begin
            errors++;
            $display("FAIL bp_second: got cyc=%0d res=%h rd=%h h=%h want 8 63 06 2", cyc, result_o, rd_o, hartid_o);
        end
        result_ready_i = 1'b1;
        step();
        result_ready_i = 1'b0;
    endtask

    task automatic test_flush();
        int seen;
        valid_i = 1'b1; operand_i = 32'h00000042; hartid_i = 2'd1; id_i = 4'd3; rd_i = 5'd5;
        step();
        valid_i = 1'b0;
        step(); step(); step();
        flush_i = 1'b1;
        valid_i = 1'b1;
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || we_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: got r=%b v=%b we=%b want 1 0 0", ready_o, valid_o, we_o);
        end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (valid_o === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_novalid: got %0d valid cycles want 0", seen);
        end
        convert("after_flush", 32'h12345678, 2'd2, 4'd5, 5'd12, 32'h00BC614E, 1'b0);
    endtask

    task automatic test_async_reset();
        valid_i = 1'b1; operand_i = 32'h00000099; hartid_i = 2'd3; id_i = 4'd15; rd_i = 5'd20;
        step();
        valid_i = 1'b0;
        step(); step();
        #2;
        rst_ni = 1'b0;
        #1;
        test_reset();
        step();
        rst_ni = 1'b1;
        step();
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_release: got r=%b v=%b want 1 0", ready_o, valid_o);
        end
        convert("after_reset", 32'h00001234, 2'd1, 4'd6, 5'd7, 32'h000004D2, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 1'b0; valid_i = 1'b0; operand_i = '0; hartid_i = '0; id_i = '0; rd_i = '0;
        flush_i = 1'b0; result_ready_i = 1'b0;
        #12;
        test_reset();
        step();
        rst_ni = 1'b1;
        step();
        test_convert();
        test_error();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
